rr_grant_encoder: RTL
=====================

// Module: rr_grant_encoder
// PURPOSE
//  Round-robin arbiter that sits directly upstream of the parameterised enable-decoder.
//  Up to 2**N requesters compete; the block registers a winner and drives the decoder with
//  an encoded winner index (grant_idx) plus an enable (grant_en). The decoder turns these
//  into the one-hot grant bus. A grant is held until released, withdrawn or timed out.
// PARAMETERS
//  N         2   index width; requester count = 2**N; must match the decoder's n
//  MAX_HOLD  15  max cycles a grant may be held before forced revoke (1..2**16-1)
// PORTS
//  clk        in   1       single rising-edge clock
//  rst_n      in   1       asynchronous, active-low reset
//  req        in   2**N    request per requester, level-sensitive
//  release    in   1       current owner done; sampled only in GRANT
//  grant_idx  out  N       encoded winner -> decoder in
//  grant_en   out  1       grant valid -> decoder enable
//  timeout    out  1       one-cycle pulse when a grant is forcibly revoked
// BEHAVIOUR
//  Interface: one clock (clk); reset rst_n is asynchronous, active-low.
//  Reset (async, immediate): state=IDLE, grant_en=0, grant_idx=0, timeout=0, ptr=0, hold_cnt=0.
//  Outputs are registered; none is combinational from req/release.
//  States: IDLE, GRANT.
//  IDLE: if |req: winner = first set bit scanning ptr, ptr+1, ... wrapping mod 2**N;
//   next edge: grant_idx<=winner, grant_en<=1, hold_cnt<=0, go GRANT. Latency req->grant_en = 1 clk.
//   If req==0: stay IDLE, grant_en=0, grant_idx holds its last value.
//  GRANT: hold_cnt increments each cycle (saturating, width clog2(MAX_HOLD+1)).
//   Exit when release=1 OR req[grant_idx]=0 OR hold_cnt==MAX_HOLD-1 (grant held MAX_HOLD cycles).
//   On exit edge: grant_en<=0, ptr<=grant_idx+1 (wraps 2**N-1 -> 0), go IDLE.
//   Timeout exit only (no release, req still set): timeout<=1 for exactly that one cycle.
//  Release and timeout in the same cycle: treated as release, timeout stays 0.
//  Back-to-back: every grant is followed by at least one cycle with grant_en=0 (IDLE re-arbitrates);
//   decoder output is therefore all-zero for >=1 cycle between owners.
//  Fairness: a requester just served has lowest priority in the next arbitration.
//  Single requester holding req: re-granted after a 1-cycle gap.
//  release while IDLE: ignored. Changes to req while in GRANT, other than req[grant_idx], are ignored.
//  rst_n low mid-grant: grant_en drops asynchronously; ptr returns to 0.
//  grant_idx is stable the whole time grant_en=1.
// STRUCTURE
//  Shared package dec_pkg: state encoding localparams (S_IDLE, S_GRANT),
//   clog2 function, default N shared with the decoder.
//  Sub-module rr_pick: purely combinational rotate-and-priority-encode
//   (req, ptr) -> (any, winner). The top holds FSM, ptr, hold_cnt and output registers.
//  Top-level test integration: grant_idx/grant_en feed the decoder's in/enable
//   (decoder d = one-hot grant).
// TESTING
//  1 reset: rst_n=0 with req=4'b1111 -> grant_en=0, grant_idx=0, timeout=0.
//    Releasing reset -> grant_idx=0 one clk later.
//  2 rotation: req=4'b1111, release pulsed each grant ->
//    grant_idx 0,1,2,3,0 with 1 idle cycle between; decoder d 0001,0000,0010,0000,0100...
//  3 wrap/skip: ptr=3, req=4'b0101 -> grant_idx=0; after release, grant_idx=2.
//  4 timeout: req=4'b0010 held, no release, MAX_HOLD=15 -> grant_en high exactly 15 cycles,
//    timeout pulse 1 cycle at the exit edge, regrant idx 1 after a 1-cycle gap.
//  5 withdraw: grant to idx 2, then req[2]=0 -> grant_en=0 next edge, timeout=0, ptr=3.
//  6 async reset mid-grant: rst_n low between edges -> grant_en=0 before next clk edge;
//    after reset, arbitration restarts from ptr=0.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared definitions for the round-robin arbiter and the downstream enable-decoder.
// Holds the FSM state type, the default index width and a constant clog2 helper.
package dec_pkg;

  localparam int DEC_N        = 2;
  localparam int DEF_MAX_HOLD = 15;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-and-priority-encode: finds the first set request
// starting at ptr and wrapping, so the requester at ptr has top priority.
module rr_pick
  import dec_pkg::*;
#(
  parameter int N = DEC_N
) (
  input  logic [(2**N)-1:0] req_i,
  input  logic [N-1:0]      ptr_i,
  output logic              any_o,
  output logic [N-1:0]      winner_o
);

  logic [N-1:0] cand;

  // Scan from the farthest offset back to ptr so the nearest set bit wins last.
  always_comb begin
    any_o    = 1'b0;
    winner_o = '0;
    cand     = '0;
    for (int i = (2**N) - 1; i >= 0; i--) begin
      cand = ptr_i + N'(i);
      if (req_i[cand]) begin
        any_o    = 1'b1;
        winner_o = cand;
      end
    end
  end

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter feeding the enable-decoder: registers an encoded winner index
// plus enable, holding the grant until release, withdrawal or a forced timeout.
module rr_grant_encoder
  import dec_pkg::*;
#(
  parameter int N        = DEC_N,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [(2**N)-1:0] req_i,
  input  logic              release_i,
  output logic [N-1:0]      grant_idx_o,
  output logic              grant_en_o,
  output logic              timeout_o
);

  localparam int            HW        = clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0] HOLD_SAT  = '1;

  state_t        state_q, state_d;
  logic [N-1:0]  ptr_q, ptr_d;
  logic [N-1:0]  grant_idx_q, grant_idx_d;
  logic          grant_en_q, grant_en_d;
  logic          timeout_q, timeout_d;
  logic [HW-1:0] hold_q, hold_d;

  logic          pick_any;
  logic [N-1:0]  pick_winner;
  logic          owner_req;
  logic          hold_done;

  rr_pick #(.N(N)) u_pick (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .any_o    (pick_any),
    .winner_o (pick_winner)
  );

  assign owner_req = req_i[grant_idx_q];
  assign hold_done = (hold_q == HOLD_LAST);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
    grant_en_d  = grant_en_q;
    timeout_d   = 1'b0;
    hold_d      = hold_q;
    unique case (state_q)
      S_IDLE: begin
        grant_en_d = 1'b0;
        if (pick_any) begin
          state_d     = S_GRANT;
          grant_idx_d = pick_winner;
          grant_en_d  = 1'b1;
          hold_d      = '0;
        end
      end
      S_GRANT: begin
        if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HW'(1);
        end
        // Release takes precedence: a timeout is flagged only when nothing else ended the grant.
        if (release_i || !owner_req || hold_done) begin
          state_d    = S_IDLE;
          grant_en_d = 1'b0;
          ptr_d      = grant_idx_q + N'(1);
          timeout_d  = !release_i && owner_req && hold_done;
        end
      end
      default: begin
        state_d    = S_IDLE;
        grant_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_idx_q <= '0;
      grant_en_q  <= 1'b0;
      timeout_q   <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      grant_en_q  <= grant_en_d;
      timeout_q   <= timeout_d;
      hold_q      <= hold_d;
    end
  end

  assign grant_idx_o = grant_idx_q;
  assign grant_en_o  = grant_en_q;
  assign timeout_o   = timeout_q;

endmodule
